// File: rtl/gcd_job_feeder.sv
// Host-side job feeder for an external GCD core: queues (A,B) jobs from the host,
// hands them to the core one at a time and queues the results for the host to read.
module gcd_job_feeder #(
    parameter int unsigned DEPTH = 8
) (
    input  logic        csi_clk,
    input  logic        rsi_reset,
    input  logic [2:0]  avs_s0_address,
    input  logic        avs_s0_write,
    input  logic [31:0] avs_s0_writedata,
    input  logic        avs_s0_read,
    output logic [31:0] avs_s0_readdata,
    output logic        coe_gcd_a_write,
    output logic        coe_gcd_b_write,
    output logic [31:0] coe_gcd_a_data,
    output logic [31:0] coe_gcd_b_data,
    output logic        coe_gcd_res_read,
    input  logic [31:0] coe_gcd_res_data,
    input  logic [7:0]  coe_gcd_res_valid
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD_A,
        ST_LOAD_B,
        ST_WAIT,
        ST_CAPTURE,
        ST_DRAIN
    } state_t;

    state_t         state_q, state_d;
    logic [31:0]    staged_a_q, staged_a_d;
    logic [31:0]    op_a_q, op_a_d;
    logic [31:0]    op_b_q, op_b_d;
    logic           in_flight_q, in_flight_d;
    logic           flush_pend_q, flush_pend_d;
    logic           ovf_q, ovf_d;
    logic           udf_q, udf_d;
    logic [31:0]    rdata_q, rdata_d;
    logic           a_write_q, a_write_d;
    logic           b_write_q, b_write_d;
    logic           res_read_q, res_read_d;
    logic [31:0]    a_data_q, a_data_d;
    logic [31:0]    b_data_q, b_data_d;

    logic [PW-1:0]  job_wr_q, job_wr_d, job_rd_q, job_rd_d;
    logic [CW-1:0]  job_cnt_q, job_cnt_d;
    logic [PW-1:0]  res_wr_q, res_wr_d, res_rd_q, res_rd_d;
    logic [CW-1:0]  res_cnt_q, res_cnt_d;

    logic [63:0]    job_mem_q [DEPTH];
    logic [31:0]    res_mem_q [DEPTH];

    logic           host_wr_a, host_push, host_flush;
    logic           job_push, job_pop, res_push, res_pop;
    logic [31:0]    res_push_data;
    logic [CW-1:0]  job_occ;
    logic           job_full, job_empty, res_full, res_empty, busy, res_valid;
    logic [63:0]    job_head;
    logic [31:0]    head_a, head_b, res_head, status;
    logic           unused_valid_hi;

    assign host_wr_a  = avs_s0_write && (avs_s0_address == 3'd0);
    assign host_push  = avs_s0_write && (avs_s0_address == 3'd1);
    assign host_flush = avs_s0_write && (avs_s0_address == 3'd4) && avs_s0_writedata[0];

    // The in-flight job still occupies a job slot until its result is captured.
    assign job_occ   = job_cnt_q + CW'(in_flight_q);
    assign job_full  = (job_occ == CW'(DEPTH));
    assign job_empty = (job_cnt_q == '0);
    assign res_full  = (res_cnt_q == CW'(DEPTH));
    assign res_empty = (res_cnt_q == '0);
    assign busy      = (state_q != ST_IDLE);
    assign res_valid = coe_gcd_res_valid[0];
    assign unused_valid_hi = ^coe_gcd_res_valid[7:1];

    assign job_head = job_mem_q[job_rd_q];
    assign head_a   = job_head[63:32];
    assign head_b   = job_head[31:0];
    assign res_head = res_mem_q[res_rd_q];
    assign status   = {16'b0, 8'(job_occ), 4'(res_cnt_q), udf_q, ovf_q, busy, res_empty};

    always_comb begin
        state_d       = state_q;
        staged_a_d    = staged_a_q;
        op_a_d        = op_a_q;
        op_b_d        = op_b_q;
        in_flight_d   = in_flight_q;
        flush_pend_d  = flush_pend_q;
        ovf_d         = ovf_q;
        udf_d         = udf_q;
        rdata_d       = '0;
        job_push      = 1'b0;
        job_pop       = 1'b0;
        res_push      = 1'b0;
        res_pop       = 1'b0;
        res_push_data = '0;

        if (host_wr_a) begin
            staged_a_d = avs_s0_writedata;
        end
        if (host_push) begin
            if (job_full) begin
                ovf_d = 1'b1;
            end else begin
                job_push = 1'b1;
            end
        end
        if (avs_s0_read) begin
            case (avs_s0_address)
                3'd2: begin
                    if (res_empty) begin
                        udf_d = 1'b1;
                    end else begin
                        rdata_d = res_head;
                        res_pop = 1'b1;
                    end
                end
                3'd3:    rdata_d = status;
                default: rdata_d = '0;
            endcase
        end

        // Dispatch only when a result slot is free, so capture can never overflow.
        case (state_q)
            ST_IDLE: begin
                if (!job_empty && !res_full) begin
                    job_pop = 1'b1;
                    if ((head_a == '0) || (head_b == '0)) begin
                        res_push      = 1'b1;
                        res_push_data = head_a | head_b;
                    end else begin
                        op_a_d      = head_a;
                        op_b_d      = head_b;
                        in_flight_d = 1'b1;
                        state_d     = ST_LOAD_A;
                    end
                end
            end
            ST_LOAD_A: state_d = ST_LOAD_B;
            ST_LOAD_B: begin
                state_d      = flush_pend_q ? ST_DRAIN : ST_WAIT;
                flush_pend_d = 1'b0;
            end
            ST_WAIT: begin
                if (res_valid) begin
                    state_d = ST_CAPTURE;
                end
            end
            ST_CAPTURE: begin
                res_push      = 1'b1;
                res_push_data = coe_gcd_res_data;
                in_flight_d   = 1'b0;
                state_d       = ST_IDLE;
            end
            ST_DRAIN: begin
                if (res_valid) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // A half-loaded core is completed with B=A so its result can be drained.
        if (host_flush) begin
            ovf_d       = 1'b0;
            udf_d       = 1'b0;
            in_flight_d = 1'b0;
            job_push    = 1'b0;
            job_pop     = 1'b0;
            res_push    = 1'b0;
            res_pop     = 1'b0;
            case (state_q)
                ST_LOAD_A: begin
                    state_d      = ST_LOAD_B;
                    op_b_d       = op_a_q;
                    flush_pend_d = 1'b1;
                end
                ST_LOAD_B, ST_WAIT, ST_DRAIN: begin
                    state_d      = ST_DRAIN;
                    flush_pend_d = 1'b0;
                end
                default: begin
                    state_d      = ST_IDLE;
                    flush_pend_d = 1'b0;
                end
            endcase
        end

        if (host_flush) begin
            job_wr_d  = '0;
            job_rd_d  = '0;
            job_cnt_d = '0;
            res_wr_d  = '0;
            res_rd_d  = '0;
            res_cnt_d = '0;
        end else begin
            job_wr_d  = job_wr_q + PW'(job_push);
            job_rd_d  = job_rd_q + PW'(job_pop);
            job_cnt_d = job_cnt_q + CW'(job_push) - CW'(job_pop);
            res_wr_d  = res_wr_q + PW'(res_push);
            res_rd_d  = res_rd_q + PW'(res_pop);
            res_cnt_d = res_cnt_q + CW'(res_push) - CW'(res_pop);
        end

        a_write_d  = (state_d == ST_LOAD_A);
        b_write_d  = (state_d == ST_LOAD_B);
        a_data_d   = (state_d == ST_LOAD_A) ? op_a_d : '0;
        b_data_d   = (state_d == ST_LOAD_B) ? op_b_d : '0;
        res_read_d = (state_d == ST_CAPTURE) || ((state_q == ST_DRAIN) && (state_d == ST_IDLE));
    end

    always_ff @(posedge csi_clk or posedge rsi_reset) begin
        if (rsi_reset) begin
            state_q      <= ST_IDLE;
            staged_a_q   <= '0;
            op_a_q       <= '0;
            op_b_q       <= '0;
            in_flight_q  <= 1'b0;
            flush_pend_q <= 1'b0;
            ovf_q        <= 1'b0;
            udf_q        <= 1'b0;
            rdata_q      <= '0;
            a_write_q    <= 1'b0;
            b_write_q    <= 1'b0;
            res_read_q   <= 1'b0;
            a_data_q     <= '0;
            b_data_q     <= '0;
            job_wr_q     <= '0;
            job_rd_q     <= '0;
            job_cnt_q    <= '0;
            res_wr_q     <= '0;
            res_rd_q     <= '0;
            res_cnt_q    <= '0;
        end else begin
            state_q      <= state_d;
            staged_a_q   <= staged_a_d;
            op_a_q       <= op_a_d;
            op_b_q       <= op_b_d;
            in_flight_q  <= in_flight_d;
            flush_pend_q <= flush_pend_d;
            ovf_q        <= ovf_d;
            udf_q        <= udf_d;
            rdata_q      <= rdata_d;
            a_write_q    <= a_write_d;
            b_write_q    <= b_write_d;
            res_read_q   <= res_read_d;
            a_data_q     <= a_data_d;
            b_data_q     <= b_data_d;
            job_wr_q     <= job_wr_d;
            job_rd_q     <= job_rd_d;
            job_cnt_q    <= job_cnt_d;
            res_wr_q     <= res_wr_d;
            res_rd_q     <= res_rd_d;
            res_cnt_q    <= res_cnt_d;
        end
    end

    always_ff @(posedge csi_clk or posedge rsi_reset) begin
        if (rsi_reset) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                job_mem_q[PW'(i)] <= '0;
                res_mem_q[PW'(i)] <= '0;
            end
        end else begin
            if (job_push) begin
                job_mem_q[job_wr_q] <= {staged_a_q, avs_s0_writedata};
            end
            if (res_push) begin
                res_mem_q[res_wr_q] <= res_push_data;
            end
        end
    end

    assign avs_s0_readdata  = rdata_q;
    assign coe_gcd_a_write  = a_write_q;
    assign coe_gcd_b_write  = b_write_q;
    assign coe_gcd_a_data   = a_data_q;
    assign coe_gcd_b_data   = b_data_q;
    assign coe_gcd_res_read = res_read_q;

endmodule

// File: tb/tb_gcd_job_feeder.sv
// Bench for gcd_job_feeder: behavioural GCD core, job/result scoreboard and directed scenarios.
module tb_gcd_job_feeder;

    logic        csi_clk = 1'b0;
    logic        rsi_reset;
    logic [2:0]  avs_s0_address;
    logic        avs_s0_write;
    logic [31:0] avs_s0_writedata;
    logic        avs_s0_read;
    logic [31:0] avs_s0_readdata;
    logic        coe_gcd_a_write, coe_gcd_b_write, coe_gcd_res_read;
    logic [31:0] coe_gcd_a_data, coe_gcd_b_data, coe_gcd_res_data;
    logic [7:0]  coe_gcd_res_valid;

    int checks = 0;
    int errors = 0;
    int a_cnt = 0, b_cnt = 0, rr_cnt = 0;
    logic a_prev = 1'b0, b_prev = 1'b0, rr_prev = 1'b0;

    int unsigned core_delay = 3;
    int unsigned core_cnt;
    logic [31:0] core_a, core_b, core_res;
    logic        core_valid, core_busy;

    logic [31:0] exp_res[$];
    logic [31:0] exp_core_a[$];
    logic [31:0] exp_core_b[$];

    always #5 csi_clk = ~csi_clk;

    gcd_job_feeder #(.DEPTH(8)) dut (
        .csi_clk          (csi_clk),
        .rsi_reset        (rsi_reset),
        .avs_s0_address   (avs_s0_address),
        .avs_s0_write     (avs_s0_write),
        .avs_s0_writedata (avs_s0_writedata),
        .avs_s0_read      (avs_s0_read),
        .avs_s0_readdata  (avs_s0_readdata),
        .coe_gcd_a_write  (coe_gcd_a_write),
        .coe_gcd_b_write  (coe_gcd_b_write),
        .coe_gcd_a_data   (coe_gcd_a_data),
        .coe_gcd_b_data   (coe_gcd_b_data),
        .coe_gcd_res_read (coe_gcd_res_read),
        .coe_gcd_res_data (coe_gcd_res_data),
        .coe_gcd_res_valid(coe_gcd_res_valid)
    );

    // Upper valid bits carry junk: only bit 0 may be honoured.
    assign coe_gcd_res_valid = {7'b1010101, core_valid};
    assign coe_gcd_res_data  = core_res;

    function automatic logic [31:0] gcd_f(input logic [31:0] a, input logic [31:0] b);
        logic [31:0] x, y, t;
        x = a;
        y = b;
        while (y != 0) begin
            t = x % y;
            x = y;
            y = t;
        end
        return x;
    endfunction

    always @(posedge csi_clk or posedge rsi_reset) begin
        if (rsi_reset) begin
            core_valid <= 1'b0;
            core_busy  <= 1'b0;
            core_cnt   <= 0;
            core_a     <= '0;
            core_b     <= '0;
            core_res   <= 32'hDEAD_BEEF;
        end else begin
            if (coe_gcd_a_write) core_a <= coe_gcd_a_data;
            if (coe_gcd_b_write) begin
                core_b    <= coe_gcd_b_data;
                core_busy <= 1'b1;
                core_cnt  <= core_delay;
            end else if (core_busy) begin
                if (core_cnt == 0) begin
                    core_valid <= 1'b1;
                    core_res   <= gcd_f(core_a, core_b);
                    core_busy  <= 1'b0;
                end else begin
                    core_cnt <= core_cnt - 1;
                end
            end
            if (coe_gcd_res_read) core_valid <= 1'b0;
        end
    end

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Per-cycle compare of the core-side strobes against the expected load sequence.
    always @(negedge csi_clk) begin
        if (rsi_reset) begin
            check32("reset_outputs",
                    {29'b0, coe_gcd_a_write, coe_gcd_b_write, coe_gcd_res_read}
                        | coe_gcd_a_data | coe_gcd_b_data | avs_s0_readdata, 32'h0);
            a_prev  = 1'b0;
            b_prev  = 1'b0;
            rr_prev = 1'b0;
        end else begin
            check32("strobe_overlap",
                    32'(int'(coe_gcd_a_write) + int'(coe_gcd_b_write) + int'(coe_gcd_res_read) > 1), 32'h0);
            if (coe_gcd_a_write) begin
                a_cnt++;
                check32("a_pulse_width", 32'(a_prev), 32'h0);
                if (exp_core_a.size() == 0) begin
                    check32("a_unexpected", 32'h1, 32'h0);
                end else begin
                    check32("a_data", coe_gcd_a_data, exp_core_a.pop_front());
                end
            end
            if (coe_gcd_b_write) begin
                b_cnt++;
                check32("b_pulse_width", 32'(b_prev), 32'h0);
                if (exp_core_b.size() == 0) begin
                    check32("b_unexpected", 32'h1, 32'h0);
                end else begin
                    check32("b_data", coe_gcd_b_data, exp_core_b.pop_front());
                end
            end
            if (coe_gcd_res_read) begin
                rr_cnt++;
                check32("res_read_pulse_width", 32'(rr_prev), 32'h0);
            end
            a_prev  = coe_gcd_a_write;
            b_prev  = coe_gcd_b_write;
            rr_prev = coe_gcd_res_read;
        end
    end

    task automatic host_write(input logic [2:0] addr, input logic [31:0] data);
        @(negedge csi_clk);
        avs_s0_address   = addr;
        avs_s0_writedata = data;
        avs_s0_write     = 1'b1;
        @(negedge csi_clk);
        avs_s0_write     = 1'b0;
    endtask

    task automatic host_read(input logic [2:0] addr, output logic [31:0] data);
        @(negedge csi_clk);
        avs_s0_address = addr;
        avs_s0_read    = 1'b1;
        @(negedge csi_clk);
        avs_s0_read    = 1'b0;
        data           = avs_s0_readdata;
    endtask

    task automatic push_job(input logic [31:0] a, input logic [31:0] b, input bit accepted);
        host_write(3'd0, a);
        host_write(3'd1, b);
        if (accepted) begin
            exp_res.push_back(gcd_f(a, b));
            if (a != 0 && b != 0) begin
                exp_core_a.push_back(a);
                exp_core_b.push_back(b);
            end
        end
    endtask

    task automatic flush_model();
        host_write(3'd4, 32'h1);
        exp_res.delete();
        exp_core_a.delete();
        exp_core_b.delete();
    endtask

    task automatic check_status(input string name, input logic [31:0] exp);
        logic [31:0] s;
        host_read(3'd3, s);
        check32(name, s, exp);
    endtask

    task automatic wait_nonempty(input string name);
        logic [31:0] s;
        int n;
        n = 0;
        s = 32'h1;
        while (s[0] && n < 200) begin
            host_read(3'd3, s);
            n++;
        end
        check32({name, "_poll_timeout"}, 32'(s[0]), 32'h0);
    endtask

    task automatic read_result(input string name, output logic [31:0] d);
        logic [31:0] e;
        wait_nonempty(name);
        host_read(3'd2, d);
        if (exp_res.size() == 0) begin
            check32({name, "_model_empty"}, 32'h1, 32'h0);
        end else begin
            e = exp_res.pop_front();
            check32(name, d, e);
        end
    endtask

    task automatic wait_rr(input int target, input string name);
        int n;
        n = 0;
        while (rr_cnt < target && n < 400) begin
            @(negedge csi_clk);
            n++;
        end
        check32({name, "_res_read_timeout"}, 32'(rr_cnt < target), 32'h0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] d;
        int a0, b0, r0;

        rsi_reset = 1'b1;
        avs_s0_address = '0;
        avs_s0_write = 1'b0;
        avs_s0_writedata = '0;
        avs_s0_read = 1'b0;
        repeat (3) @(negedge csi_clk);
        rsi_reset = 1'b0;

        // Reset state: empty, idle, no flags.
        check32("readdata_after_reset", avs_s0_readdata, 32'h0);
        check_status("status_after_reset", 32'h0000_0001);

        // Basic job through the core.
        a0 = a_cnt; b0 = b_cnt; r0 = rr_cnt;
        push_job(32'd48, 32'd18, 1'b1);
        read_result("gcd_48_18", d);
        check32("gcd_48_18_literal", d, 32'd6);
        check32("a_write_count", 32'(a_cnt - a0), 32'd1);
        check32("b_write_count", 32'(b_cnt - b0), 32'd1);
        check32("res_read_count", 32'(rr_cnt - r0), 32'd1);

        // Zero operands bypass the core.
        a0 = a_cnt; b0 = b_cnt; r0 = rr_cnt;
        push_job(32'd0, 32'd35, 1'b1);
        push_job(32'd0, 32'd0, 1'b1);
        read_result("gcd_0_35", d);
        check32("gcd_0_35_literal", d, 32'd35);
        read_result("gcd_0_0", d);
        check32("gcd_0_0_literal", d, 32'd0);
        check32("zero_op_no_strobes", 32'((a_cnt - a0) + (b_cnt - b0) + (rr_cnt - r0)), 32'd0);

        // Underflow, unmapped read, non-flush write to flush address, real flush.
        host_read(3'd2, d);
        check32("underflow_read_data", d, 32'h0);
        check_status("status_underflow", 32'h0000_0009);
        host_read(3'd5, d);
        check32("unmapped_read", d, 32'h0);
        host_write(3'd4, 32'h0);
        check_status("status_flush_bit0_clear", 32'h0000_0009);
        flush_model();
        check_status("status_after_flush", 32'h0000_0001);

        // Overflow with the core stalled; in-flight job counts toward the limit.
        core_delay = 150;
        r0 = rr_cnt;
        for (int i = 0; i < 9; i++) begin
            push_job(32'(12 + 6 * i), 32'd8, i < 8);
        end
        check_status("status_overflow", 32'h0000_0807);
        flush_model();
        check_status("status_draining", 32'h0000_0003);
        wait_rr(r0 + 1, "overflow_drain");
        a0 = a_cnt;
        repeat (5) @(negedge csi_clk);
        check_status("status_after_drain", 32'h0000_0001);
        check32("no_dispatch_after_flush", 32'(a_cnt - a0), 32'd0);

        // Full result FIFO blocks dispatch until the host frees a slot.
        core_delay = 2;
        for (int k = 1; k <= 8; k++) begin
            push_job(32'd0, 32'(k), 1'b1);
        end
        repeat (3) @(negedge csi_clk);
        check_status("status_result_full", 32'h0000_0080);
        a0 = a_cnt; b0 = b_cnt;
        push_job(32'd20, 32'd15, 1'b1);
        repeat (5) @(negedge csi_clk);
        check_status("status_blocked_job", 32'h0000_0180);
        check32("blocked_no_strobe", 32'(a_cnt - a0), 32'd0);
        read_result("first_of_full", d);
        check32("first_of_full_literal", d, 32'd1);
        while (exp_res.size() > 0) read_result("full_fifo_order", d);
        check32("last_result_literal", d, 32'd5);
        check32("unblocked_a_count", 32'(a_cnt - a0), 32'd1);
        check32("unblocked_b_count", 32'(b_cnt - b0), 32'd1);

        // Flush while waiting on a slow core.
        core_delay = 20;
        b0 = b_cnt; r0 = rr_cnt;
        push_job(32'd100, 32'd75, 1'b1);
        for (int n = 0; n < 50 && b_cnt == b0; n++) @(negedge csi_clk);
        check32("wait_b_write_seen", 32'(b_cnt - b0), 32'd1);
        repeat (3) @(negedge csi_clk);
        flush_model();
        check_status("status_drain_from_wait", 32'h0000_0003);
        wait_rr(r0 + 1, "wait_drain");
        repeat (25) @(negedge csi_clk);
        check32("drain_single_res_read", 32'(rr_cnt - r0), 32'd1);
        check_status("status_after_wait_drain", 32'h0000_0001);

        // Asynchronous reset during LOAD_B.
        core_delay = 5;
        push_job(32'd30, 32'd12, 1'b1);
        for (int n = 0; n < 20 && !coe_gcd_b_write; n++) @(negedge csi_clk);
        check32("load_b_reached", 32'(coe_gcd_b_write), 32'h1);
        #2;
        rsi_reset = 1'b1;
        #1;
        check32("async_reset_outputs",
                {29'b0, coe_gcd_a_write, coe_gcd_b_write, coe_gcd_res_read}
                    | coe_gcd_a_data | coe_gcd_b_data | avs_s0_readdata, 32'h0);
        exp_res.delete();
        exp_core_a.delete();
        exp_core_b.delete();
        repeat (2) @(negedge csi_clk);
        rsi_reset = 1'b0;
        check_status("status_after_async_reset", 32'h0000_0001);
        push_job(32'd21, 32'd14, 1'b1);
        read_result("gcd_21_14", d);
        check32("gcd_21_14_literal", d, 32'd7);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
